ifetch_unit: RTL
================

// Module: ifetch_unit
// PURPOSE
//  Instruction-fetch stage; the consumer of the PC generator's next-PC output and the producer of
//  its instruction input. Accepts a PC, issues one read on the instruction-memory port, buffers the
//  returned word with its PC and presents it to the PC generator via a valid/ready handshake.
//  Discards in-flight and buffered words on redirect (taken JAL) so only on-path words are delivered.
// PARAMETERS
//  XLEN       32            address/data width
//  BUF_DEPTH  2             instruction buffer entries (power of 2, >=2)
//  NOP_INSTR  32'h00000013  word delivered for a misaligned PC (addi x0,x0,0)
// PORTS
//  clk           in   1     clock, rising edge
//  rst_n         in   1     reset, synchronous, active-low
//  pc_valid_i    in   1     next PC valid from PC generator
//  pc_i          in   XLEN  next PC
//  pc_ready_o    out  1     PC accepted when pc_valid_i && pc_ready_o
//  redirect_i    in   1     control-flow change: flush buffer, drop in-flight response
//  imem_req_o    out  1     memory read request; held until imem_gnt_i
//  imem_addr_o   out  XLEN  read address, stable while imem_req_o
//  imem_gnt_i    in   1     request accepted this cycle
//  imem_rvalid_i in   1     read data valid (exactly one per grant, >=1 cycle after gnt)
//  imem_rdata_i  in   32    read data
//  instr_valid_o out  1     buffer non-empty
//  instr_o       out  32    head instruction
//  instr_pc_o    out  XLEN  PC of head instruction
//  instr_fault_o out  1     head entry came from a misaligned PC
//  instr_ready_i in   1     consumer pops head when instr_valid_o && instr_ready_i
// BEHAVIOUR
//  Reset: state IDLE, buffer empty, drop flag 0; all outputs 0 (pc_ready_o 0 during reset).
//  FSM IDLE/REQ/WAIT, one request outstanding max:
//   IDLE: pc_ready_o = (count < BUF_DEPTH). On accept with pc_i[1:0]==0: latch addr -> REQ.
//         On accept with pc_i[1:0]!=0: no memory access; push {NOP_INSTR, pc_i, fault=1}; stay IDLE.
//   REQ:  imem_req_o=1, imem_addr_o=latched PC; on imem_gnt_i -> WAIT. Request never withdrawn.
//   WAIT: on imem_rvalid_i push {imem_rdata_i, latched PC, fault=0} unless drop=1; -> IDLE, drop<=0.
//   pc_ready_o=0 in REQ and WAIT.
//  Latency (zero-wait memory): PC accepted cycle N -> req N+1 (gnt N+1) -> rvalid N+2 ->
//   instr_valid_o N+3. Back-to-back throughput: 1 instruction / 3 cycles.
//  Buffer: FIFO, registered outputs; push visible next cycle; pop and push same cycle allowed when
//   full (count unchanged). Push never occurs when full: the slot is reserved by IDLE's count check.
//  Redirect (redirect_i=1), highest priority:
//   - buffer emptied next cycle (count=0, instr_valid_o=0), pops that cycle ignored
//   - REQ/WAIT: drop<=1; response of in-flight read discarded; rvalid in same cycle also discarded
//   - IDLE with pc_valid_i same cycle: flush AND accept new PC (new PC is on-path)
//   - redirect in REQ/WAIT with pc_valid_i: PC not accepted (pc_ready_o=0); generator holds it
//  Pointers wrap modulo BUF_DEPTH; count width clog2(BUF_DEPTH)+1.
//  Reset mid-operation: FSM/buffer/drop cleared; a later stray rvalid in IDLE is ignored.
// STRUCTURE
//  cpu_configuration package: xlen, NOP_INSTR constant, ifetch_state_e {IDLE,REQ,WAIT},
//   ifetch_entry_t {fault, pc, instr}.
//  Sub-module ifetch_buffer: parametric FIFO of ifetch_entry_t with push/pop/flush/count.
//  Top holds FSM, address latch, drop flag, misalignment check.
// TESTING
//  1 PC 0x0 accepted, gnt same cycle, rvalid+1 data 0x00500093 -> instr_valid_o 3 cycles after
//    accept, instr_o=0x00500093, instr_pc_o=0x0, fault=0.
//  2 gnt delayed 4 cycles -> imem_req_o/imem_addr_o stable all 4 cycles, pc_ready_o=0 throughout.
//  3 instr_ready_i=0, feed PCs 0x0,0x4,0x8 -> two entries buffered, pc_ready_o=0 at count=2;
//    one pop -> 0x8 accepted next cycle; order 0x0,0x4,0x8 preserved.
//  4 redirect_i in WAIT, rvalid 2 cycles later -> word discarded, buffer empty, next PC 0x100
//    fetched and delivered with instr_pc_o=0x100.
//  5 redirect_i + pc_valid_i(0x200) in IDLE with 2 buffered -> buffer empties, 0x200 delivered next.
//  6 PC 0x6 -> no imem_req_o, entry {0x00000013, 0x6, fault=1}; rst_n low mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared CPU configuration for the instruction-fetch stage: widths, the NOP word,
// FSM state encoding and the buffered-instruction record.
package ifetch_unit_pkg;

    localparam int CPU_XLEN = 32;
    localparam logic [31:0] CPU_NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic                fault;
        logic [CPU_XLEN-1:0] pc;
        logic [31:0]         instr;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_buffer.sv
// Small FIFO of fetched instructions. Flush empties it, and a push in the same
// cycle as a flush lands as the sole surviving entry.
module ifetch_buffer
    import ifetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  ifetch_entry_t push_entry,
    input  logic          pop,
    output ifetch_entry_t head,
    output logic          valid,
    output logic [CW-1:0] count
);

    ifetch_entry_t mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic [PW-1:0] wr_addr_s;

    // Qualify push/pop; a pop during a flush is discarded.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        wr_addr_s = wr_ptr_r;
        if (flush) begin
            push_ok_s = push;
            wr_addr_s = '0;
        end else begin
            pop_ok_s  = pop && (count_r != '0);
            push_ok_s = push && ((count_r < CW'(DEPTH)) || pop_ok_s);
        end
    end

    // Entry storage; contents are only observed through the count-qualified head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_addr_s] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= push_ok_s ? PW'(1) : '0;
            count_r  <= push_ok_s ? CW'(1) : '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    assign valid = (count_r != '0);
    assign count = count_r;
    assign head  = valid ? mem_r[rd_ptr_r] : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: takes PCs from the PC generator, reads instruction memory
// one request at a time, and buffers on-path words for the consumer.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int          XLEN      = CPU_XLEN,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_ready_o,
    input  logic            redirect_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_fault_o,
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    ifetch_state_e state_r;
    ifetch_state_e state_next_s;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] addr_next_s;
    logic            drop_r;
    logic            drop_next_s;
    logic            pc_ready_s;
    logic            push_s;
    ifetch_entry_t   push_entry_s;
    ifetch_entry_t   head_s;
    logic            buf_valid_s;
    logic [CW-1:0]   buf_count_s;

    // Next-state, address latch, drop flag and buffer push decisions.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        drop_next_s  = drop_r;
        pc_ready_s   = 1'b0;
        push_s       = 1'b0;
        push_entry_s = '0;
        case (state_r)
            IDLE: begin
                drop_next_s = 1'b0;
                // A redirect frees every slot, so the new on-path PC may enter even when full.
                pc_ready_s = rst_n && ((buf_count_s < CW'(BUF_DEPTH)) || redirect_i);
                if (pc_valid_i && pc_ready_s) begin
                    if (pc_i[1:0] != 2'b00) begin
                        push_s             = 1'b1;
                        push_entry_s.fault = 1'b1;
                        push_entry_s.pc    = pc_i;
                        push_entry_s.instr = NOP_INSTR;
                    end else begin
                        addr_next_s  = pc_i;
                        state_next_s = REQ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    drop_next_s = 1'b1;
                end else begin
                    drop_next_s = drop_r;
                end
                if (imem_gnt_i) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_next_s = IDLE;
                    drop_next_s  = 1'b0;
                    if (!drop_r && !redirect_i) begin
                        push_s             = 1'b1;
                        push_entry_s.fault = 1'b0;
                        push_entry_s.pc    = addr_r;
                        push_entry_s.instr = imem_rdata_i;
                    end else begin
                        push_s = 1'b0;
                    end
                end else if (redirect_i) begin
                    drop_next_s = 1'b1;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
                drop_next_s  = 1'b0;
            end
        endcase
    end

    // FSM, latched fetch address and drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= '0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            addr_r  <= addr_next_s;
            drop_r  <= drop_next_s;
        end
    end

    ifetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_i),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (instr_ready_i),
        .head       (head_s),
        .valid      (buf_valid_s),
        .count      (buf_count_s)
    );

    assign pc_ready_o    = pc_ready_s;
    assign imem_req_o    = rst_n && (state_r == REQ);
    assign imem_addr_o   = imem_req_o ? addr_r : '0;
    assign instr_valid_o = buf_valid_s;
    assign instr_o       = head_s.instr;
    assign instr_pc_o    = head_s.pc;
    assign instr_fault_o = head_s.fault;

endmodule
